bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbitrates the single-port system RAM between the 6502 core and a DMA engine (sprite/block copy).
- CPU owns the bus by default. DMA steals cycles by stalling the core through RDY.
- Steals only begin on CPU read cycles: the NMOS 6502 ignores RDY during writes.
- Sits between the core, the DMA engine and the RAM in the top-level system, clocked by the same clk as the core.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- MAX_BURST, 64, consecutive DMA grants before a forced CPU cycle (used only with ARB_FAIRNESS_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_we  in  1  CPU write strobe (1=write, 0=read)
- cpu_rdy  out  1  1 = CPU access performed this cycle; 0 = CPU stalled
- cpu_rdata  out  DW  CPU read data, valid the cycle after a performed read
- dma_req  in  1  DMA requests bus this cycle
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_we  in  1  DMA write strobe
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  DW  DMA read data
- dma_rvalid  out  1  dma_rdata valid (one cycle after a granted DMA read)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DW  RAM read data, synchronous, 1-cycle latency

Behaviour:
- States: CPU_OWN (reset), DMA_OWN, FAIR.
- The bus mux is combinational from state and inputs. The state register, burst counter and read-owner flag are registered.
- CPU_OWN:
  - Take (DMA gets bus this cycle): dma_req=1 and cpu_we=0 → dma_gnt=1, cpu_rdy=0, mem driven by dma_*; next state DMA_OWN; burst count=1.
  - Defer: dma_req=1 and cpu_we=1 → CPU write performed (cpu_rdy=1), dma_gnt=0; DMA waits and retries next cycle.
  - Otherwise the CPU is performed (cpu_rdy=1), mem driven by cpu_*.
- DMA_OWN:
  - dma_req=1 → dma_gnt=1, cpu_rdy=0, count+1. The CPU stays frozen on the same read; it holds cpu_addr, and the read is re-presented later.
  - dma_req=0 → the CPU is performed in the same cycle (no dead cycle); next state CPU_OWN; count=0.
- FAIR (only with ARB_FAIRNESS_EN):
  - Exactly one CPU cycle is performed (cpu_rdy=1) and dma_gnt=0 regardless of dma_req; count=0.
  - Next state: DMA_OWN if dma_req=1 and cpu_we=0, else CPU_OWN.
- Read return:
  - Registered rd_owner records who issued a performed read.
  - Next cycle: cpu_rdata=mem_rdata if CPU, else dma_rdata=mem_rdata and dma_rvalid=1.
  - cpu_rdata holds its last value otherwise. dma_rvalid=0 otherwise.
- Invariants:
  - dma_gnt and cpu_rdy are never both 1.
  - mem_we=1 only when the owning side's we=1 and it is performed.
  - cpu_rdy=0 is never asserted in a cycle with cpu_we=1.
- Burst counter:
  - Width $clog2(MAX_BURST+1); saturates at MAX_BURST.
  - Never wraps.
- Reset:
  - While rst=1: state→CPU_OWN, count→0, rd_owner→CPU, dma_rvalid=0, dma_gnt=0, mem_we=0, cpu_rdy=1, cpu_rdata→0.
  - Reset asserted mid-burst aborts the burst; the DMA engine sees dma_gnt=0 and must re-request.
- Simultaneous dma_req rising and cpu_we=1: the CPU wins; there is no queuing beyond dma_req held high.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- Defined: when a grant takes count to MAX_BURST, the next state is FAIR, guaranteeing ≥1 CPU cycle per MAX_BURST+1 cycles.
- Undefined: FAIR is unreachable; DMA holds the bus as long as dma_req=1 and the counter is for debug only.

Decomposition:
- Package bus_pkg holds:
  - typedef enum logic [1:0] arb_state_e {CPU_OWN, DMA_OWN, FAIR};
  - typedef enum logic owner_e {OWN_CPU, OWN_DMA};
  - localparams ADDR_W=16 and DATA_W=8.
- Sub-module dma_burst_ctr: saturating counter with clr/inc/at_max. Used only for fairness.

Test Plan:
- Reset then idle, CPU reads 0x1234 → cpu_rdy=1, mem_addr=0x1234, cpu_rdata=RAM[0x1234] next cycle.
- CPU writes 0x55 to 0x0200 while dma_req=1 → CPU write completes, dma_gnt=0. The next CPU read cycle gives dma_gnt=1, cpu_rdy=0.
- DMA 4-beat read from 0x0300–0x0303 during CPU read of 0x8000:
  - 4 cycles with cpu_rdy=0.
  - dma_rvalid pulses lag 1 cycle each with correct data.
  - The CPU read of 0x8000 completes the cycle dma_req drops.
- With ARB_FAIRNESS_EN and MAX_BURST=4, dma_req held 10 cycles → grant pattern 1111 0 1111 0, CPU performed in each gap.
- rst asserted at the 2nd beat of a DMA burst → same cycle dma_gnt=0, mem_we=0, cpu_rdy=1. After release the state is CPU_OWN.
- Random CPU/DMA traffic (1000 cycles, scoreboard RAM model) → never both granted, no CPU-write stall, all read data matches the model.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default widths for the CPU/DMA system-RAM arbiter.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    FAIR    = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/dma_burst_ctr.sv
// Saturating count of consecutive DMA grants. at_max flags that the update
// applied at the coming edge leaves the count at MAX_BURST.
module dma_burst_ctr #(
  parameter int MAX_BURST = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(MAX_BURST);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  // clr together with inc starts a fresh burst at one grant.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = inc ? CW'(1) : '0;
    end else if (inc && (count != MAX_VAL)) begin
      count_nxt = count + CW'(1);
    end
  end

  assign at_max = inc && (count_nxt == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-port RAM arbiter: the 6502 owns the bus, DMA steals read cycles via RDY.
// Define ARB_FAIRNESS_EN to force one CPU cycle after every MAX_BURST DMA grants.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW        = ADDR_W,
  parameter int DW        = DATA_W,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_we,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state, state_nxt, state_d;
  owner_e        rd_owner;
  logic          rd_pend;
  logic [DW-1:0] cpu_rdata_q;
  logic          cpu_go, dma_go;
  logic          ctr_clr, ctr_inc, at_max;
  logic          cpu_ret;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cpu_go    = 1'b1;
    dma_go    = 1'b0;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
    if (!rst) begin
      unique case (state)
        CPU_OWN: begin
          // The NMOS 6502 ignores RDY on writes, so a steal can only start on a read.
          if (dma_req && !cpu_we) begin
            cpu_go    = 1'b0;
            dma_go    = 1'b1;
            ctr_clr   = 1'b1;
            ctr_inc   = 1'b1;
            state_nxt = DMA_OWN;
          end
        end
        DMA_OWN: begin
          if (dma_req) begin
            cpu_go  = 1'b0;
            dma_go  = 1'b1;
            ctr_inc = 1'b1;
          end else begin
            ctr_clr   = 1'b1;
            state_nxt = CPU_OWN;
          end
        end
        FAIR: begin
          ctr_clr   = 1'b1;
          state_nxt = (dma_req && !cpu_we) ? DMA_OWN : CPU_OWN;
        end
        default: state_nxt = CPU_OWN;
      endcase
    end
  end

  dma_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .inc    (ctr_inc),
    .at_max (at_max)
  );

`ifdef ARB_FAIRNESS_EN
  assign state_d = (dma_go && at_max) ? FAIR : state_nxt;
`else
  logic burst_unused;
  assign burst_unused = at_max;
  assign state_d      = state_nxt;
`endif

  assign cpu_rdy   = cpu_go;
  assign dma_gnt   = dma_go;
  assign mem_addr  = dma_go ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_go ? dma_wdata : cpu_wdata;
  assign mem_we    = (dma_go && dma_we) || (cpu_go && cpu_we && !rst);

  // RAM data arrives the cycle after the address; route it to whoever issued the read.
  assign cpu_ret    = rd_pend && (rd_owner == OWN_CPU) && !rst;
  assign cpu_rdata  = cpu_ret ? mem_rdata : cpu_rdata_q;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = rd_pend && (rd_owner == OWN_DMA) && !rst;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CPU_OWN;
      rd_owner    <= OWN_CPU;
      rd_pend     <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state    <= state_d;
      rd_pend  <= (cpu_go && !cpu_we) || (dma_go && !dma_we);
      rd_owner <= dma_go ? OWN_DMA : OWN_CPU;
      if (cpu_ret) cpu_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a synchronous RAM.
// Expected fairness pattern follows ARB_FAIRNESS_EN with MAX_BURST=4.
module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic        dma_req = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        dma_we = 1'b0;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  bus_arbiter #(.AW(16), .DW(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdy    (cpu_rdy),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_we     (dma_we),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  task automatic drive(input logic c_we, input logic [15:0] c_a, input logic [7:0] c_d,
                       input logic d_req, input logic d_we, input logic [15:0] d_a,
                       input logic [7:0] d_d);
    cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    dma_req = d_req; dma_we = d_we; dma_addr = d_a; dma_wdata = d_d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
  endtask

  task automatic test_reset;
    drive(1'b0, 16'h1234, 8'h0, 1'b1, 1'b1, 16'h0300, 8'hAA);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", dma_rvalid); end
    tick();
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", cpu_rdata); end
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL idle_rdy: got %b want 1", cpu_rdy); end
    tick();
  endtask

  task automatic preload;
    cpu_write(16'h0000, 8'h00);
    cpu_write(16'h1234, 8'hA5);
    cpu_write(16'h0201, 8'h9E);
    cpu_write(16'h0400, 8'h3C);
    cpu_write(16'h0300, 8'h10);
    cpu_write(16'h0301, 8'h21);
    cpu_write(16'h0302, 8'h32);
    cpu_write(16'h0303, 8'h43);
    cpu_write(16'h8000, 8'hC7);
    cpu_write(16'h0601, 8'h00);
  endtask

  task automatic test_cpu_read;
    drive(1'b0, 16'h1234, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rd_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (mem_addr !== 16'h1234) begin n_bad++; $display("FAIL rd_addr: got %h want 1234", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", mem_we); end
    tick();
    drive(1'b1, 16'h0010, 8'h77, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", cpu_rdata); end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", mem_we); end
    tick();
    drive(1'b0, 16'h0010, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_hold: got %h want a5", cpu_rdata); end
    tick();
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'h77) begin n_bad++; $display("FAIL rd_after_wr: got %h want 77", cpu_rdata); end
    tick();
  endtask

  task automatic test_defer;
    drive(1'b1, 16'h0200, 8'h55, 1'b1, 1'b0, 16'h0400, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL defer_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (dma_gnt !== 1'b0) begin n_bad++; $display("FAIL defer_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (mem_addr !== 16'h0200) begin n_bad++; $display("FAIL defer_addr: got %h want 0200", mem_addr); end
    tick();
    drive(1'b0, 16'h0201, 8'h0, 1'b1, 1'b0, 16'h0400, 8'h0);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b1) begin n_bad++; $display("FAIL take_gnt: got %b want 1", dma_gnt); end
    n_cmp++; if (cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL take_rdy: got %b want 0", cpu_rdy); end
    n_cmp++; if (mem_addr !== 16'h0400) begin n_bad++; $display("FAIL take_addr: got %h want 0400", mem_addr); end
    tick();
    drive(1'b0, 16'h0201, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL release_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL take_rvalid: got %b want 1", dma_rvalid); end
    n_cmp++; if (dma_rdata !== 8'h3C) begin n_bad++; $display("FAIL take_rdata: got %h want 3c", dma_rdata); end
    n_cmp++; if (ram[16'h0200] !== 8'h55) begin n_bad++; $display("FAIL defer_ram: got %h want 55", ram[16'h0200]); end
    tick();
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL defer_rvalid_lo: got %b want 0", dma_rvalid); end
    n_cmp++; if (cpu_rdata !== 8'h9E) begin n_bad++; $display("FAIL defer_cpu_rdata: got %h want 9e", cpu_rdata); end
    tick();
  endtask

  task automatic test_dma_burst;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h43;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 16'h8000, 8'h0, (i < 4), 1'b0, 16'h0300 + 16'(i), 8'h0);
      @(negedge clk);
      n_cmp++; if (dma_gnt !== (i < 4)) begin n_bad++; $display("FAIL burst_gnt[%0d]: got %b want %b", i, dma_gnt, (i < 4)); end
      n_cmp++; if (cpu_rdy !== (i == 4)) begin n_bad++; $display("FAIL burst_rdy[%0d]: got %b want %b", i, cpu_rdy, (i == 4)); end
      if (i > 0) begin
        n_cmp++; if (dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL burst_rvalid[%0d]: got %b want 1", i, dma_rvalid); end
        n_cmp++; if (dma_rdata !== exp_d[i-1]) begin n_bad++; $display("FAIL burst_rdata[%0d]: got %h want %h", i, dma_rdata, exp_d[i-1]); end
      end
      if (i == 4) begin
        n_cmp++; if (mem_addr !== 16'h8000) begin n_bad++; $display("FAIL burst_cpu_addr: got %h want 8000", mem_addr); end
      end
      tick();
    end
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'hC7) begin n_bad++; $display("FAIL burst_cpu_rdata: got %h want c7", cpu_rdata); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL burst_rvalid_end: got %b want 0", dma_rvalid); end
    tick();
  endtask

  task automatic test_fairness;
    logic exp_g;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'h9000, 8'h0, 1'b1, 1'b0, 16'h0500 + 16'(i), 8'h0);
`ifdef ARB_FAIRNESS_EN
      exp_g = (i % 5) != 4;
`else
      exp_g = 1'b1;
`endif
      @(negedge clk);
      n_cmp++; if (dma_gnt !== exp_g) begin n_bad++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, dma_gnt, exp_g); end
      n_cmp++; if (cpu_rdy !== !exp_g) begin n_bad++; $display("FAIL fair_rdy[%0d]: got %b want %b", i, cpu_rdy, !exp_g); end
      tick();
    end
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL fair_release: got %b want 1", cpu_rdy); end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    drive(1'b0, 16'h0010, 8'h0, 1'b1, 1'b1, 16'h0600, 8'hE1);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b1) begin n_bad++; $display("FAIL rmb_beat0: got %b want 1", dma_gnt); end
    tick();
    rst = 1'b1;
    drive(1'b0, 16'h0010, 8'h0, 1'b1, 1'b1, 16'h0601, 8'hE2);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b0) begin n_bad++; $display("FAIL rmb_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmb_we: got %b want 0", mem_we); end
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rmb_rdy: got %b want 1", cpu_rdy); end
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0700, 8'h11, 1'b1, 1'b0, 16'h0010, 8'h0);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b0) begin n_bad++; $display("FAIL rmb_state_gnt: got %b want 0", dma_gnt); end
    n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rmb_state_rdy: got %b want 1", cpu_rdy); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rmb_rdata_clr: got %h want 00", cpu_rdata); end
    n_cmp++; if (ram[16'h0600] !== 8'hE1) begin n_bad++; $display("FAIL rmb_ram0: got %h want e1", ram[16'h0600]); end
    n_cmp++; if (ram[16'h0601] !== 8'h00) begin n_bad++; $display("FAIL rmb_ram1: got %h want 00", ram[16'h0601]); end
    tick();
    drive(1'b0, 16'h0700, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h0);
    @(negedge clk);
    n_cmp++; if (dma_gnt !== 1'b1) begin n_bad++; $display("FAIL rmb_regrant: got %b want 1", dma_gnt); end
    tick();
    drive(1'b0, 16'h0700, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (dma_rdata !== 8'h77 || dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL rmb_dma_rdata: got %h/%b want 77/1", dma_rdata, dma_rvalid); end
    tick();
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_cmp++; if (cpu_rdata !== 8'h11) begin n_bad++; $display("FAIL rmb_cpu_rdata: got %h want 11", cpu_rdata); end
    tick();
  endtask

  task automatic test_random;
    logic [7:0] shadow [256];
    logic [7:0] v, e_cpu, e_dma;
    logic [15:0] e_addr;
    logic p_cpu, p_dma, s_rdy, s_gnt, s_req, e_we;
    int grants;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      shadow[i] = v;
      cpu_write({8'hA0, 8'(i)}, v);
    end
    p_cpu = 1'b0; p_dma = 1'b0; e_cpu = '0; e_dma = '0; grants = 0;
    drive(1'b0, {8'hA0, 8'($urandom)}, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (1000) begin
      @(negedge clk);
      if (p_cpu) begin
        n_cmp++; if (cpu_rdata !== e_cpu) begin n_bad++; $display("FAIL rnd_cpu_rdata: got %h want %h", cpu_rdata, e_cpu); end
      end
      n_cmp++; if (dma_rvalid !== p_dma) begin n_bad++; $display("FAIL rnd_rvalid: got %b want %b", dma_rvalid, p_dma); end
      if (p_dma) begin
        n_cmp++; if (dma_rdata !== e_dma) begin n_bad++; $display("FAIL rnd_dma_rdata: got %h want %h", dma_rdata, e_dma); end
      end
      n_cmp++; if ((dma_gnt && cpu_rdy) !== 1'b0) begin n_bad++; $display("FAIL rnd_exclusive: gnt %b rdy %b", dma_gnt, cpu_rdy); end
      if (cpu_we) begin
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rnd_write_stall: got %b want 1", cpu_rdy); end
      end
      e_we = (cpu_rdy && cpu_we) || (dma_gnt && dma_we);
      n_cmp++; if (mem_we !== e_we) begin n_bad++; $display("FAIL rnd_mem_we: got %b want %b", mem_we, e_we); end
      e_addr = dma_gnt ? dma_addr : cpu_addr;
      n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL rnd_mem_addr: got %h want %h", mem_addr, e_addr); end
      p_cpu = cpu_rdy && !cpu_we;
      p_dma = dma_gnt && !dma_we;
      if (cpu_rdy) begin
        if (cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
        else e_cpu = shadow[cpu_addr[7:0]];
      end
      if (dma_gnt) begin
        grants++;
        if (dma_we) shadow[dma_addr[7:0]] = dma_wdata;
        else e_dma = shadow[dma_addr[7:0]];
      end
      s_rdy = cpu_rdy; s_gnt = dma_gnt; s_req = dma_req;
      tick();
      if (s_rdy) begin
        cpu_we = (($urandom % 3) == 0);
        cpu_addr = {8'hA0, 8'($urandom)};
        cpu_wdata = 8'($urandom);
      end
      if (s_gnt || !s_req) begin
        dma_req = (($urandom % 3) != 0);
        dma_we = 1'($urandom);
        dma_addr = {8'hA0, 8'($urandom)};
        dma_wdata = 8'($urandom);
      end
    end
    n_cmp++; if (grants == 0) begin n_bad++; $display("FAIL rnd_no_grants: got %0d want >0", grants); end
    drive(1'b0, 16'h0000, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    preload();
    test_cpu_read();
    test_defer();
    test_dma_burst();
    test_fairness();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
